// File: rtl/if_prefetch_queue.sv
// ----------------------------------------------------------------------------
// if_prefetch_queue
//
// Instruction prefetch queue sitting between the instruction cache and the
// fetch stage. It walks the PC forward one word at a time, keeps at most one
// icache request outstanding, and buffers up to DEPTH returned instructions
// together with their PCs. The head entry is offered to fetch over a
// valid/ready handshake. A redirect flushes everything, kills any in-flight
// icache request and restarts fetching at the new PC; a misaligned restart PC
// produces a single exception entry and halts fetching until the next
// redirect.
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   ic_req_o       icache request (held with ic_addr_o until ic_ack_i)
//   ic_addr_o      icache request address (current fetch PC)
//   ic_kill_o      abort the in-flight icache request
//   ic_ack_i       icache response valid, completes the current request
//   ic_rdata_i     icache response instruction
//   redirect_i     flush and restart at redirect_pc_i
//   redirect_pc_i  restart PC
//   deq_valid_o    head entry valid
//   deq_ready_i    fetch consumes the head entry
//   deq_instr_o    head instruction (NOP for an exception entry)
//   deq_pc_o       head PC
//   deq_misalign_o head is a misaligned-PC exception entry
//   count_o        current occupancy
// ----------------------------------------------------------------------------
module if_prefetch_queue #(
    parameter int unsigned            DEPTH    = 4,
    parameter int unsigned            XLEN     = 32,
    parameter logic [XLEN-1:0]        PC_RESET = 32'h8000_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      ic_req_o,
    output logic [XLEN-1:0]           ic_addr_o,
    output logic                      ic_kill_o,
    input  logic                      ic_ack_i,
    input  logic [31:0]               ic_rdata_i,
    input  logic                      redirect_i,
    input  logic [XLEN-1:0]           redirect_pc_i,
    output logic                      deq_valid_o,
    input  logic                      deq_ready_i,
    output logic [31:0]               deq_instr_o,
    output logic [XLEN-1:0]           deq_pc_o,
    output logic                      deq_misalign_o,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_RUN,
        S_KILL,
        S_HALT
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            misalign;
    } entry_t;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    // Low for the first cycle after reset so the icache sees the request drop.
    logic            req_en_q;
    entry_t          mem_q [DEPTH];

    logic req_raw;
    logic push;
    logic pop;
    logic redir_misalign;

    // Request that would be presented absent a redirect. A request, once
    // raised, stays up until ack because count cannot grow without an ack.
    assign req_raw        = (state_q == S_RUN) & req_en_q & (count_q < DEPTH_C);
    assign ic_req_o       = req_raw & ~redirect_i;
    assign ic_addr_o      = fetch_pc_q;
    assign ic_kill_o      = redirect_i & req_raw;

    assign push           = ic_req_o & ic_ack_i;
    assign pop            = deq_valid_o & deq_ready_i & ~redirect_i;
    assign redir_misalign = redirect_i & (redirect_pc_i[1:0] != 2'b00);

    assign deq_valid_o    = (count_q != '0);
    assign deq_pc_o       = mem_q[rd_ptr_q].pc;
    assign deq_instr_o    = mem_q[rd_ptr_q].instr;
    assign deq_misalign_o = mem_q[rd_ptr_q].misalign;
    assign count_o        = count_q;

    // NOTE: every variable gets a default first so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        if (redirect_i) begin
            // Redirect wins over any push/pop in the same cycle.
            fetch_pc_d = redirect_pc_i;
            rd_ptr_d   = '0;
            if (redir_misalign) begin
                // The exception entry lands in slot 0.
                count_d  = CW'(1);
                wr_ptr_d = PW'(1);
                state_d  = S_HALT;
            end else begin
                count_d  = '0;
                wr_ptr_d = '0;
                state_d  = S_KILL;
            end
        end else begin
            if (state_q == S_KILL) begin
                state_d = S_RUN;
            end
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PW'(1);
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RUN;
            fetch_pc_q <= PC_RESET;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            req_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            req_en_q   <= 1'b1;
        end
    end

    // NOTE: the entry storage has no reset; count_q alone decides which
    // entries are meaningful, so clearing the array would only cost logic.
    always_ff @(posedge clk) begin
        if (redir_misalign) begin
            mem_q[0] <= '{pc: redirect_pc_i, instr: NOP, misalign: 1'b1};
        end else if (push) begin
            mem_q[wr_ptr_q] <= '{pc: fetch_pc_q, instr: ic_rdata_i, misalign: 1'b0};
        end
    end

endmodule

// File: tb/tb_if_prefetch_queue.sv
module tb_if_prefetch_queue;

    localparam logic [31:0] A   = 32'h8000_0000;
    localparam logic [31:0] W   = 32'hFFFF_FFF0;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_req_o;
    logic [31:0] ic_addr_o;
    logic        ic_kill_o;
    logic        ic_ack_i;
    logic [31:0] ic_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        deq_valid_o;
    logic        deq_ready_i;
    logic [31:0] deq_instr_o;
    logic [31:0] deq_pc_o;
    logic        deq_misalign_o;
    logic [2:0]  count_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    if_prefetch_queue #(
        .DEPTH(4), .XLEN(32), .PC_RESET(32'h8000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ic_req_o       (ic_req_o),
        .ic_addr_o      (ic_addr_o),
        .ic_kill_o      (ic_kill_o),
        .ic_ack_i       (ic_ack_i),
        .ic_rdata_i     (ic_rdata_i),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .deq_valid_o    (deq_valid_o),
        .deq_ready_i    (deq_ready_i),
        .deq_instr_o    (deq_instr_o),
        .deq_pc_o       (deq_pc_o),
        .deq_misalign_o (deq_misalign_o),
        .count_o        (count_o)
    );

    // Instruction word the icache model returns for a given address.
    function automatic logic [31:0] tag(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0000;
    endfunction

    typedef struct {
        logic        rst, ack, redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        kill, valid;
        logic [31:0] dpc;
        logic        mis;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic r, input logic ak, input logic rd,
                       input logic [31:0] rp, input logic ry,
                       input logic q, input logic [31:0] ad, input logic k,
                       input logic v, input logic [31:0] dp, input logic m,
                       input logic [2:0] c);
        vec_t e;
        e.rst = r; e.ack = ak; e.redir = rd; e.rpc = rp; e.rdy = ry;
        e.req = q; e.addr = ad; e.kill = k; e.valid = v; e.dpc = dp;
        e.mis = m; e.cnt = c;
        vt.push_back(e);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Compare every output against one expected record.
    task automatic check_vec(input int idx, input vec_t e);
        n_vec++;
        check("ic_req", idx, {31'b0, ic_req_o}, {31'b0, e.req});
        check("ic_kill", idx, {31'b0, ic_kill_o}, {31'b0, e.kill});
        check("deq_valid", idx, {31'b0, deq_valid_o}, {31'b0, e.valid});
        check("count", idx, {29'b0, count_o}, {29'b0, e.cnt});
        if (e.req) check("ic_addr", idx, ic_addr_o, e.addr);
        if (e.valid) begin
            check("deq_pc", idx, deq_pc_o, e.dpc);
            check("deq_misalign", idx, {31'b0, deq_misalign_o}, {31'b0, e.mis});
            check("deq_instr", idx, deq_instr_o, e.mis ? NOP : tag(e.dpc));
        end
    endtask

    task automatic drive(input vec_t e);
        rst           = e.rst;
        ic_ack_i      = e.ack;
        redirect_i    = e.redir;
        redirect_pc_i = e.rpc;
        deq_ready_i   = e.rdy;
        ic_rdata_i    = e.req ? tag(e.addr) : 32'hDEAD_BEEF;
    endtask

    initial begin
        vec_t e;
        int   waited;

        //   rst ack red rpc          rdy  req addr        kill val dpc         mis cnt
        // Back-to-back streaming with fetch always ready.
        add(0, 1, 0, 0,           1,   0, 0,           0, 0, 0,           0, 0);
        add(0, 1, 0, 0,           1,   1, A,           0, 0, 0,           0, 0);
        add(0, 1, 0, 0,           1,   1, A + 32'h04,  0, 1, A,           0, 1);
        add(0, 1, 0, 0,           1,   1, A + 32'h08,  0, 1, A + 32'h04,  0, 1);
        add(0, 1, 0, 0,           1,   1, A + 32'h0C,  0, 1, A + 32'h08,  0, 1);
        // Fetch stalls: fill to DEPTH, then one pop re-enables requests.
        add(0, 1, 0, 0,           0,   1, A + 32'h10,  0, 1, A + 32'h0C,  0, 1);
        add(0, 1, 0, 0,           0,   1, A + 32'h14,  0, 1, A + 32'h0C,  0, 2);
        add(0, 1, 0, 0,           0,   1, A + 32'h18,  0, 1, A + 32'h0C,  0, 3);
        add(0, 1, 0, 0,           0,   0, 0,           0, 1, A + 32'h0C,  0, 4);
        add(0, 1, 0, 0,           1,   0, 0,           0, 1, A + 32'h0C,  0, 4);
        add(0, 0, 0, 0,           0,   1, A + 32'h1C,  0, 1, A + 32'h10,  0, 3);
        // Redirect with pending request and a same-cycle ack that must drop.
        add(0, 1, 1, A + 32'h100, 1,   0, 0,           1, 1, A + 32'h10,  0, 3);
        add(0, 0, 0, 0,           1,   0, 0,           0, 0, 0,           0, 0);
        add(0, 1, 0, 0,           1,   1, A + 32'h100, 0, 0, 0,           0, 0);
        add(0, 0, 0, 0,           0,   1, A + 32'h104, 0, 1, A + 32'h100, 0, 1);
        // Misaligned redirect: exception entry, then halt until a redirect.
        add(0, 0, 1, A + 32'h102, 0,   0, 0,           1, 1, A + 32'h100, 0, 1);
        add(0, 1, 0, 0,           0,   0, 0,           0, 1, A + 32'h102, 1, 1);
        add(0, 1, 0, 0,           1,   0, 0,           0, 1, A + 32'h102, 1, 1);
        add(0, 1, 0, 0,           1,   0, 0,           0, 0, 0,           0, 0);
        add(0, 0, 1, A + 32'h200, 1,   0, 0,           0, 0, 0,           0, 0);
        add(0, 1, 0, 0,           1,   0, 0,           0, 0, 0,           0, 0);
        add(0, 1, 0, 0,           1,   1, A + 32'h200, 0, 0, 0,           0, 0);
        add(0, 0, 0, 0,           1,   1, A + 32'h204, 0, 1, A + 32'h200, 0, 1);
        // Restart near the top of the address space: full, pop, wrap.
        add(0, 0, 1, W,           0,   0, 0,           1, 0, 0,           0, 0);
        add(0, 1, 0, 0,           0,   0, 0,           0, 0, 0,           0, 0);
        add(0, 1, 0, 0,           0,   1, W,           0, 0, 0,           0, 0);
        add(0, 1, 0, 0,           0,   1, W + 32'h4,   0, 1, W,           0, 1);
        add(0, 1, 0, 0,           0,   1, W + 32'h8,   0, 1, W,           0, 2);
        add(0, 0, 0, 0,           0,   1, W + 32'hC,   0, 1, W,           0, 3);
        add(0, 1, 0, 0,           0,   1, W + 32'hC,   0, 1, W,           0, 3);
        add(0, 1, 0, 0,           1,   0, 0,           0, 1, W,           0, 4);
        add(0, 1, 0, 0,           1,   1, 32'h0,       0, 1, W + 32'h4,   0, 3);
        add(0, 0, 0, 0,           0,   1, 32'h4,       0, 1, W + 32'h8,   0, 3);
        add(0, 0, 0, 0,           1,   1, 32'h4,       0, 1, W + 32'h8,   0, 3);
        // Reset mid-request with two entries queued.
        add(1, 0, 0, 0,           0,   1, 32'h4,       0, 1, W + 32'hC,   0, 2);
        add(0, 1, 0, 0,           1,   0, 0,           0, 0, 0,           0, 0);
        add(0, 1, 0, 0,           1,   1, A,           0, 0, 0,           0, 0);
        add(0, 0, 0, 0,           0,   1, A + 32'h04,  0, 1, A,           0, 1);

        rst = 1'b1; ic_ack_i = 1'b0; ic_rdata_i = '0; redirect_i = 1'b0;
        redirect_pc_i = '0; deq_ready_i = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            drive(vt[i]);
            #1;
            check_vec(i, vt[i]);
        end

        // Steady state: one instruction per cycle, occupancy stays at one.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            e = '{rst: 0, ack: 1, redir: 0, rpc: 0, rdy: 1,
                  req: 1, addr: A + 32'h04 + 32'(4 * i), kill: 0, valid: 1,
                  dpc: A + 32'(4 * i), mis: 0, cnt: 3'd1};
            drive(e);
            #1;
            check_vec(100 + i, e);
        end

        // Stop acking and let fetch drain; the queue must empty in bounded time.
        @(negedge clk);
        ic_ack_i = 1'b0;
        deq_ready_i = 1'b1;
        waited = 0;
        #1;
        while (deq_valid_o !== 1'b0 && waited < 6) begin
            @(negedge clk);
            #1;
            waited++;
        end
        n_vec++;
        if (deq_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL drain_timeout: deq_valid %b after %0d cycles, expected 0", deq_valid_o, waited);
        end
        check("drain_count", 200, {29'b0, count_o}, 32'd0);
        check("drain_req", 200, {31'b0, ic_req_o}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
